// File: rtl/scroll_loader_fsm.sv
// -----------------------------------------------------------------------------
// scroll_loader_fsm
//
// Streams a program scroll into array BASE_ADDR of mem_sys before the control
// unit is released from reset. Bytes arrive over a valid/ready stream. They are
// packed big-endian into 32-bit platters. Each platter is written with one
// mem_in_bus_t write at consecutive offsets.
//
// Ports:
//   clk         system clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   start       begin a load (sampled in IDLE and DONE only)
//   byte_in     stream data byte
//   byte_valid  byte_in is valid
//   byte_last   byte_in is the final byte of the scroll (with byte_valid)
//   byte_ready  loader accepts a byte this cycle
//   mem_in      {mode, address, offset, data} towards the loader's mem_in_bus_buf
//   bus_en      enable for the loader's mem_in_bus_buf
//   done        load finished (success or error)
//   error       truncated scroll or overflow; valid while done=1
//   word_count  platters written so far
// -----------------------------------------------------------------------------

package scroll_loader_pkg;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
  } mem_in_bus_t;

  localparam logic [1:0] MODE_NOP   = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;

endpackage

module scroll_loader_fsm
  import scroll_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MAX_WORDS = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_last,
  output logic        byte_ready,
  output mem_in_bus_t mem_in,
  output logic        bus_en,
  output logic        done,
  output logic        error,
  output logic [31:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [31:0] r_count;
  logic        r_error;
  logic        r_last_pend;

  state_t      w_state_nxt;
  logic [31:0] w_shift_nxt;
  logic [1:0]  w_idx_nxt;
  logic [31:0] w_count_nxt;
  logic        w_error_nxt;
  logic        w_last_pend_nxt;

  // Outputs are decoded from the state register only. Reset therefore
  // forces them to zero the instant reset_n falls, with no clock edge.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that leaves a signal unassigned would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_count_nxt     = r_count;
    w_error_nxt     = r_error;
    w_last_pend_nxt = r_last_pend;
    byte_ready      = 1'b0;
    bus_en          = 1'b0;
    done            = 1'b0;
    mem_in          = '0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_COLLECT;
          w_count_nxt     = '0;
          w_idx_nxt       = '0;
          w_error_nxt     = 1'b0;
          w_last_pend_nxt = 1'b0;
        end
      end

      S_COLLECT: begin
        byte_ready = 1'b1;
        bus_en     = 1'b1;
        if (byte_valid) begin
          // The first byte of a platter ends up in bits [31:24].
          w_shift_nxt = {r_shift[23:0], byte_in};
          if (r_idx == 2'd3) begin
            if (r_count < MAX_WORDS) begin
              w_state_nxt     = S_WRITE;
              w_last_pend_nxt = byte_last;
            end else begin
              // The platter is complete but there is no room left for it.
              w_state_nxt = S_DONE;
              w_error_nxt = 1'b1;
            end
          end else if (byte_last) begin
            // The scroll ended mid-platter. The partial word is dropped.
            w_state_nxt = S_DONE;
            w_error_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end

      S_WRITE: begin
        bus_en          = 1'b1;
        mem_in.mode     = MODE_WRITE;
        mem_in.address  = BASE_ADDR;
        mem_in.offset   = r_count;
        mem_in.data     = r_shift;
        w_count_nxt     = r_count + 32'd1;
        w_idx_nxt       = '0;
        w_last_pend_nxt = 1'b0;
        w_state_nxt     = r_last_pend ? S_DONE : S_COLLECT;
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt     = S_COLLECT;
          w_count_nxt     = '0;
          w_idx_nxt       = '0;
          w_error_nxt     = 1'b0;
          w_last_pend_nxt = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values present before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_error     <= 1'b0;
      r_last_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_count     <= w_count_nxt;
      r_error     <= w_error_nxt;
      r_last_pend <= w_last_pend_nxt;
    end
  end

  assign error      = r_error;
  assign word_count = r_count;

endmodule

// File: tb/tb_scroll_loader_fsm.sv
// -----------------------------------------------------------------------------
// tb_scroll_loader_fsm
//
// Self-checking bench for scroll_loader_fsm. There are two instances:
//   - dut_big uses the default capacity.
//   - dut_small uses MAX_WORDS=2 to reach the overflow path.
// A shared stimulus port is steered to one instance by sel. Expected writes
// come from a byte-level model and go into a queue. A monitor pops and
// compares them when a write appears on the selected mem_in. A small memory
// model records every write so that reads can be checked afterwards.
// -----------------------------------------------------------------------------

module tb_scroll_loader_fsm;
  import scroll_loader_pkg::*;

  localparam logic [31:0] BASE       = 32'h0;
  localparam logic [31:0] BIG_MAX    = 32'h0001_0000;
  localparam logic [31:0] SMALL_MAX  = 32'd2;

  typedef struct {
    logic [31:0] offset;
    logic [31:0] data;
  } exp_wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        sel;

  logic        start_b, valid_b, ready_b, bus_en_b, done_b, error_b;
  logic        start_s, valid_s, ready_s, bus_en_s, done_s, error_s;
  logic [31:0] count_b, count_s;
  mem_in_bus_t mem_in_b, mem_in_s;

  logic        byte_ready, bus_en, done, error;
  logic [31:0] word_count;
  mem_in_bus_t mem_in;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_wr_t     exp_q[$];
  logic [31:0] mem_model[int];
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  assign start_b = start & ~sel;
  assign valid_b = byte_valid & ~sel;
  assign start_s = start & sel;
  assign valid_s = byte_valid & sel;

  assign byte_ready = sel ? ready_s  : ready_b;
  assign bus_en     = sel ? bus_en_s : bus_en_b;
  assign done       = sel ? done_s   : done_b;
  assign error      = sel ? error_s  : error_b;
  assign word_count = sel ? count_s  : count_b;
  assign mem_in     = sel ? mem_in_s : mem_in_b;

  scroll_loader_fsm #(.BASE_ADDR(BASE), .MAX_WORDS(BIG_MAX)) dut_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .byte_in(byte_in),
    .byte_valid(valid_b), .byte_last(byte_last), .byte_ready(ready_b),
    .mem_in(mem_in_b), .bus_en(bus_en_b), .done(done_b), .error(error_b),
    .word_count(count_b)
  );

  scroll_loader_fsm #(.BASE_ADDR(BASE), .MAX_WORDS(SMALL_MAX)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(start_s), .byte_in(byte_in),
    .byte_valid(valid_s), .byte_last(byte_last), .byte_ready(ready_s),
    .mem_in(mem_in_s), .bus_en(bus_en_s), .done(done_s), .error(error_s),
    .word_count(count_s)
  );

  // Write monitor. Every non-no-op mem_in cycle must match the oldest
  // expected write.
  always @(negedge clk) begin
    if (mem_in.mode !== MODE_NOP) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got mode=%b off=%0d data=%h, required no write",
                 mem_in.mode, mem_in.offset, mem_in.data);
      end else begin
        exp_wr_t e;
        mem_in_bus_t want;
        e    = exp_q.pop_front();
        want = '{mode: MODE_WRITE, address: BASE, offset: e.offset, data: e.data};
        if (mem_in !== want || bus_en !== 1'b1)
          $display("FAIL write: got %h bus_en=%b, required %h bus_en=1",
                   mem_in, bus_en, want);
        else
          n_pass++;
      end
      if (mem_in.mode === MODE_WRITE && bus_en === 1'b1)
        mem_model[int'(mem_in.offset)] = mem_in.data;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    byte_last  = last;
    ok         = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (byte_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  // Sends tx_q with last on the final byte and models the expected writes.
  // It then checks done, error, word_count and that every expected write
  // appeared.
  task automatic run_scroll(input string name, input bit toggle, input logic [31:0] max_w);
    logic [31:0] m_shift = '0;
    int          m_idx   = 0;
    logic [31:0] m_count = '0;
    logic        m_err   = 1'b0;
    bit          ok;
    for (int i = 0; i < tx_q.size(); i++) begin
      logic last;
      last = (i == tx_q.size() - 1);
      send_byte(tx_q[i], last, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL %s_handshake: byte %0d not accepted within budget, required accept", name, i);
        return;
      end
      n_pass++;
      m_shift = {m_shift[23:0], tx_q[i]};
      if (m_idx == 3) begin
        m_idx = 0;
        if (m_count < max_w) begin
          exp_q.push_back('{offset: m_count, data: m_shift});
          m_count++;
        end else begin
          m_err = 1'b1;
        end
      end else if (last) begin
        m_err = 1'b1;
      end else begin
        m_idx++;
      end
      if (toggle && !last) @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s_done: got %b, required 1", name, done);
    else n_pass++;
    n_checks++;
    if (error !== m_err) $display("FAIL %s_error: got %b, required %b", name, error, m_err);
    else n_pass++;
    n_checks++;
    if (word_count !== m_count)
      $display("FAIL %s_word_count: got %0d, required %0d", name, word_count, m_count);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_missing_writes: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
    n_checks++;
    if (done !== 1'b1 || bus_en !== 1'b0 || byte_ready !== 1'b0)
      $display("FAIL %s_done_hold: got done=%b bus_en=%b ready=%b, required 1/0/0",
               name, done, bus_en, byte_ready);
    else n_pass++;
  endtask

  task automatic check_mem(input string name, input int off, input logic [31:0] want);
    logic [31:0] got;
    got = mem_model.exists(off) ? mem_model[off] : 32'hxxxx_xxxx;
    n_checks++;
    if (got !== want) $display("FAIL %s_mem[%0d]: got %h, required %h", name, off, got, want);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (byte_ready !== 1'b0 || bus_en !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
        word_count !== 32'd0 || mem_in !== '0)
      $display("FAIL %s_outputs: got ready=%b bus_en=%b done=%b err=%b wc=%0d mem_in=%h, required all 0",
               name, byte_ready, bus_en, done, error, word_count, mem_in);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_all_zero("reset_big");
    sel = 1'b1;
    #1 check_all_zero("reset_small");
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle");
  endtask

  task automatic test_single();
    do_start();
    n_checks++;
    if (byte_ready !== 1'b1 || bus_en !== 1'b1 || done !== 1'b0)
      $display("FAIL single_collect: got ready=%b bus_en=%b done=%b, required 1/1/0",
               byte_ready, bus_en, done);
    else n_pass++;
    tx_q = '{8'h30, 8'h00, 8'h00, 8'h0A};
    run_scroll("single", 1'b0, BIG_MAX);
    check_mem("single", 0, 32'h3000000A);
  endtask

  task automatic test_toggle();
    do_start();
    n_checks++;
    if (done !== 1'b0 || word_count !== 32'd0 || error !== 1'b0)
      $display("FAIL toggle_restart: got done=%b wc=%0d err=%b, required 0/0/0",
               done, word_count, error);
    else n_pass++;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    run_scroll("toggle", 1'b1, BIG_MAX);
    check_mem("toggle", 0, 32'h01020304);
    check_mem("toggle", 1, 32'hA0B0C0D0);
  endtask

  task automatic test_truncated();
    do_start();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_scroll("truncated", 1'b0, BIG_MAX);
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    do_start();
    tx_q.delete();
    for (int i = 0; i < 12; i++) tx_q.push_back(8'(8'hC0 + i));
    run_scroll("overflow", 1'b0, SMALL_MAX);
    sel = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_start();
    send_byte(8'hDE, 1'b0, ok);
    send_byte(8'hAD, 1'b0, ok);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    do_start();
    tx_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_scroll("after_reset", 1'b0, BIG_MAX);
    check_mem("after_reset", 0, 32'h12345678);
  endtask

  task automatic test_back_to_back();
    do_start();
    tx_q = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
    run_scroll("b2b_first", 1'b0, BIG_MAX);
    do_start();
    tx_q = '{8'hFE, 8'hDC, 8'hBA, 8'h98};
    run_scroll("b2b_restart", 1'b0, BIG_MAX);
    check_mem("b2b_restart", 0, 32'hFEDCBA98);
    check_mem("b2b_keep", 1, 32'h4B5A6978);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    sel        = 1'b0;
    test_reset();
    test_single();
    test_toggle();
    test_truncated();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
